// File: rtl/rsff_ctrl_seq_if.sv
// rsff_ctrl_seq_if: valid/ready command channel into the RS flop-bank sequencer.
interface rsff_ctrl_seq_if #(parameter int WIDTH = 8);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_data;
    modport master (output req_valid, req_op, req_data, input req_ready);
    modport slave  (input req_valid, req_op, req_data, output req_ready);
endinterface

// File: rtl/rsff_ctrl_seq.sv
// rsff_ctrl_seq: turns commands and an async clear into glitch-free data/set/reset drive
// for a negedge-clocked RS flop bank, with minimum pulse widths and a guard gap.
module rsff_ctrl_seq #(
    parameter int WIDTH        = 8,
    parameter int PULSE_CYCLES = 2,
    parameter int GUARD_CYCLES = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    rsff_ctrl_seq_if.slave   req,
    input  logic             ext_clr_async,
    output logic [WIDTH-1:0] ff_d,
    output logic             ff_reset,
    output logic             ff_set,
    output logic             busy,
    output logic             done
);
    localparam int CMAX = PULSE_CYCLES > GUARD_CYCLES ? PULSE_CYCLES : GUARD_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam logic [CW-1:0] PC = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] GC = CW'(GUARD_CYCLES);
    typedef enum logic [2:0] {INIT, IDLE, LOAD, PULSE, GUARD} state_t;
    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev, pending, quiet, clr_edge, pend_n;
    logic [1:0]             op;
    assign clr_edge = sync[SYNC_STAGES-1] & ~sync_prev;
    // a clear already driving ff_reset absorbs any new clear request
    assign pend_n = pending | (clr_edge & ~(state == PULSE && ff_reset));
    assign op = pending ? 2'b01 : req.req_op;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= INIT;
            cnt           <= '0;
            sync          <= '0;
            sync_prev     <= 1'b0;
            pending       <= 1'b0;
            quiet         <= 1'b1;
            ff_d          <= '0;
            ff_reset      <= 1'b1;
            ff_set        <= 1'b0;
            req.req_ready <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], ext_clr_async};
            sync_prev <= sync[SYNC_STAGES-1];
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending || (req.req_valid && req.req_ready)) begin
                        pending       <= pending ? 1'b0 : clr_edge;
                        req.req_ready <= 1'b0;
                        busy          <= 1'b1;
                        cnt           <= CW'(1);
                        if (op == 2'b01 || op == 2'b10) begin
                            state    <= PULSE;
                            ff_d     <= {WIDTH{op[1]}};
                            ff_reset <= op[0];
                            ff_set   <= op[1];
                            done     <= PULSE_CYCLES == 1 && GUARD_CYCLES == 0;
                        end else begin
                            state <= LOAD;
                            done  <= 1'b1;
                            if (op == 2'b00) ff_d <= req.req_data;
                        end
                    end else if (clr_edge) begin
                        pending       <= 1'b1;
                        req.req_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    pending       <= pend_n;
                    req.req_ready <= ~pend_n;
                end
                GUARD: begin
                    pending <= pend_n;
                    if (cnt == GC) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        quiet         <= 1'b0;
                        req.req_ready <= ~pend_n;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        done <= ~quiet && cnt + 1'b1 == GC;
                    end
                end
                default: begin
                    // INIT and PULSE share timing; quiet suppresses done for the power-up pulse
                    pending <= pend_n;
                    if (cnt == PC) begin
                        ff_reset <= 1'b0;
                        ff_set   <= 1'b0;
                        cnt      <= CW'(1);
                        if (GUARD_CYCLES == 0) begin
                            state         <= IDLE;
                            busy          <= 1'b0;
                            quiet         <= 1'b0;
                            req.req_ready <= ~pend_n;
                        end else begin
                            state <= GUARD;
                            done  <= ~quiet && GUARD_CYCLES == 1;
                        end
                    end else begin
                        cnt  <= cnt + 1'b1;
                        done <= ~quiet && GUARD_CYCLES == 0 && cnt + 1'b1 == PC;
                    end
                end
            endcase
        end
    end
endmodule
